// File: rtl/slot_monitor_pkg.sv
// Shared constants and helpers for the slot occupancy monitor:
// active-low 7-segment digit patterns and a population count.
package slot_monitor_pkg;

    // Largest supported channel count and the width that holds 0..MAX_CH.
    localparam int MAX_CH = 99;
    localparam int CNT_W  = 7;

    // Active-low segment patterns, bit0 = a .. bit6 = g.
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000    // 9
    };

    // Number of set bits in a zero-extended channel vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_CH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Segment pattern for one decimal digit; out-of-range values blank the digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] r;
        r = 7'b1111111;
        for (int i = 0; i < 10; i++) begin
            if (d == 4'(i)) begin
                r = SEG_DIGIT[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/slot_monitor_if.sv
// Sensor inputs and display/status outputs of the slot monitor.
// All signals are plain levels; there is no valid/ready handshake:
// inputs may change at any time and outputs simply hold their value.
interface slot_monitor_if #(
    parameter int N_CH = 4
) ();
    logic [N_CH-1:0] ldr;
    logic            ir;
    logic            arduino;
    logic            p1;
    logic [6:0]      seg;
    logic [6:0]      seg2;
    logic            led1;
    logic            led2;
    logic            led3;

    // Environment side: drives the sensors, observes the display.
    modport master (
        output ldr, ir,
        input  arduino, p1, seg, seg2, led1, led2, led3
    );

    // Monitor side.
    modport slave (
        input  ldr, ir,
        output arduino, p1, seg, seg2, led1, led2, led3
    );
endinterface

// File: rtl/slot_monitor_ch_debounce.sv
// One sensor channel: 2-flop synchroniser followed by a debouncer that
// accepts a new level only after DEB_CYCLES consecutive mismatching samples.
module ch_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);
    localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous sensor into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive mismatches; accept the new level on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/slot_monitor.sv
// Multi-channel parking-slot monitor: debounces N_CH light sensors, counts
// free slots, shows the count on two 7-segment digits and three status LEDs,
// forwards a synchronised IR signal and generates a heartbeat on p1.
module slot_monitor
    import slot_monitor_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEB_CYCLES = 16,
    parameter int HB_DIV     = 25000000
) (
    input  logic           clk,
    input  logic           reset_n,
    slot_monitor_if.slave  bus
);
    localparam int               OCC_W    = $clog2(N_CH + 1);
    localparam int               HB_W     = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_DIV - 1);
    localparam logic [CNT_W-1:0] N_CH_V   = CNT_W'(N_CH);
    localparam logic [6:0]       RST_ONES = SEG_DIGIT[N_CH % 10];
    localparam logic [6:0]       RST_TENS = SEG_DIGIT[N_CH / 10];

    logic [N_CH-1:0]   stable;
    logic [MAX_CH-1:0] stable_ext;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  free;
    logic [3:0]        tens;
    logic [3:0]        ones;
    logic              ir_s1;
    logic              ir_s2;
    logic              arduino_q;
    logic [HB_W-1:0]   hb_cnt;
    logic              p1_q;
    logic [6:0]        seg_q;
    logic [6:0]        seg2_q;
    logic              led1_q;
    logic              led2_q;
    logic              led3_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (bus.ldr[i]),
            .stable  (stable[i])
        );
    end

    assign stable_ext = MAX_CH'(stable);

    // Register the number of occupied slots from the debounced levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ <= '0;
        end else begin
            occ <= OCC_W'(popcount(stable_ext));
        end
    end

    // Free count and its decimal split; occ never exceeds N_CH.
    always_comb begin
        free = N_CH_V - CNT_W'(occ);
        tens = 4'(free / CNT_W'(10));
        ones = 4'(free % CNT_W'(10));
    end

    // Registered display and status LEDs; exactly one LED is lit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q  <= RST_ONES;
            seg2_q <= RST_TENS;
            led1_q <= 1'b1;
            led2_q <= 1'b0;
            led3_q <= 1'b0;
        end else begin
            seg_q  <= seg_encode(ones);
            seg2_q <= seg_encode(tens);
            led1_q <= (free == N_CH_V);
            led3_q <= (free == '0);
            led2_q <= (free != N_CH_V) && (free != '0);
        end
    end

    // IR pass-through: two synchroniser flops plus the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_s1     <= 1'b0;
            ir_s2     <= 1'b0;
            arduino_q <= 1'b0;
        end else begin
            ir_s1     <= bus.ir;
            ir_s2     <= ir_s1;
            arduino_q <= ir_s2;
        end
    end

    // Heartbeat: toggle p1 each time the divider wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_cnt <= '0;
            p1_q   <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            p1_q   <= ~p1_q;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    assign bus.arduino = arduino_q;
    assign bus.p1      = p1_q;
    assign bus.seg     = seg_q;
    assign bus.seg2    = seg2_q;
    assign bus.led1    = led1_q;
    assign bus.led2    = led2_q;
    assign bus.led3    = led3_q;
endmodule

// File: tb/tb_slot_monitor.sv
// Self-checking bench for slot_monitor with randomised sensor stimulus and a
// history-based reference model of the display and status outputs.
`timescale 1ns/1ps
module tb_slot_monitor;
    localparam int N_CH   = 4;
    localparam int DEB    = 4;
    localparam int HB     = 8;
    localparam int N_WIDE = 12;

    localparam logic [6:0] DIG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    // {seg2, seg, led1, led2, led3, arduino, p1} right after reset, N_CH=4.
    localparam logic [18:0] RESET_VEC = {7'b1000000, 7'b0011001, 5'b10000};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    slot_monitor_if #(.N_CH(N_CH))   bus ();
    slot_monitor_if #(.N_CH(N_WIDE)) bus_w ();

    slot_monitor #(.N_CH(N_CH), .DEB_CYCLES(DEB), .HB_DIV(HB)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    slot_monitor #(.N_CH(N_WIDE), .DEB_CYCLES(DEB), .HB_DIV(HB)) dut_w (
        .clk(clk), .reset_n(reset_n), .bus(bus_w)
    );

    logic [18:0] obs;
    assign obs = {bus.seg2, bus.seg, bus.led1, bus.led2, bus.led3, bus.arduino, bus.p1};

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- reference model ----------------
    // Raw samples taken at each clock edge; a channel's accepted level flips
    // once the DEB most recent samples seen by the debouncer all disagree
    // with it. Sensors reach the debouncer two edges late, and the display
    // lags the accepted levels by two further edges.
    logic [N_CH-1:0] ldr_hist[$];
    logic            ir_hist[$];
    logic [N_CH-1:0] stab_hist[$];
    logic [N_CH-1:0] m_stable;
    int              m_edges;

    task automatic model_clear();
        ldr_hist.delete();
        ir_hist.delete();
        stab_hist.delete();
        for (int k = 0; k < DEB + 2; k++) ldr_hist.push_back('0);
        for (int k = 0; k < 2; k++) begin
            ir_hist.push_back(1'b0);
            stab_hist.push_back('0);
        end
        m_stable = '0;
        m_edges  = 0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_clear();
        end else begin
            ldr_hist.push_back(bus.ldr);
            ir_hist.push_back(bus.ir);
            for (int ch = 0; ch < N_CH; ch++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (ldr_hist[ldr_hist.size() - 3 - k][ch] == m_stable[ch]) all_diff = 1'b0;
                if (all_diff) m_stable[ch] = ~m_stable[ch];
            end
            stab_hist.push_back(m_stable);
            m_edges++;
            while (ldr_hist.size() > 32) void'(ldr_hist.pop_front());
            while (ir_hist.size() > 32) void'(ir_hist.pop_front());
            while (stab_hist.size() > 32) void'(stab_hist.pop_front());
        end
    end

    function automatic logic [18:0] exp_vec();
        int fr;
        fr = N_CH - $countones(stab_hist[stab_hist.size() - 3]);
        return {DIG[fr / 10], DIG[fr % 10], fr == N_CH, (fr != N_CH) && (fr != 0),
                fr == 0, ir_hist[ir_hist.size() - 3], 1'((m_edges / HB) % 2)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        bus.ldr = '0;
        bus.ir = 1'b0;
        bus_w.ldr = '0;
        bus_w.ir = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (obs !== RESET_VEC) begin
            tests_failed++;
            $display("FAIL reset_values: got %b expected %b", obs, RESET_VEC);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL reset_model k=%0d: got %b expected %b", k, obs, exp_vec());
            end
            if (k == 7 || k == 8 || k == 15 || k == 16) begin
                tests_run++;
                if (bus.p1 !== ((k == 8 || k == 15) ? 1'b1 : 1'b0)) begin
                    tests_failed++;
                    $display("FAIL heartbeat k=%0d: got %b expected %b", k, bus.p1, (k == 8 || k == 15));
                end
            end
        end
    endtask

    task automatic test_single();
        bus.ldr = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL single_model k=%0d: got %b expected %b", k, obs, exp_vec());
            end
            tests_run++;
            if (k < 8 && (bus.seg !== DIG[4] || bus.led1 !== 1'b1)) begin
                tests_failed++;
                $display("FAIL single_early k=%0d: got seg=%b led1=%b expected seg=%b led1=1", k, bus.seg, bus.led1, DIG[4]);
            end else if (k >= 8 && (bus.seg !== 7'b0110000 || bus.led2 !== 1'b1)) begin
                tests_failed++;
                $display("FAIL single_latency k=%0d: got seg=%b led2=%b expected seg=0110000 led2=1", k, bus.seg, bus.led2);
            end
        end
    endtask

    task automatic test_glitch();
        bit saw_two;
        bus.ldr[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) bus.ldr[2] = 1'b0;
            tests_run++;
            if (obs !== exp_vec() || bus.seg !== DIG[3]) begin
                tests_failed++;
                $display("FAIL glitch_short k=%0d: got %b expected %b", k, obs, exp_vec());
            end
        end
        saw_two = 1'b0;
        bus.ldr[2] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 4) bus.ldr[2] = 1'b0;
            if (bus.seg === DIG[2]) saw_two = 1'b1;
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL glitch_long k=%0d: got %b expected %b", k, obs, exp_vec());
            end
        end
        tests_run++;
        if (!saw_two || bus.seg !== DIG[3]) begin
            tests_failed++;
            $display("FAIL glitch_accept: got saw_two=%b seg=%b expected saw_two=1 seg=%b", saw_two, bus.seg, DIG[3]);
        end
    endtask

    task automatic test_back_to_back();
        bus.ldr = 4'b0000;
        repeat (10) @(negedge clk);
        bus.ldr = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL all_model k=%0d: got %b expected %b", k, obs, exp_vec());
            end
            tests_run++;
            if (k < 8 && bus.seg !== DIG[4]) begin
                tests_failed++;
                $display("FAIL all_intermediate k=%0d: got seg=%b expected %b", k, bus.seg, DIG[4]);
            end else if (k >= 8 && (bus.seg !== DIG[0] || bus.seg2 !== DIG[0] || bus.led3 !== 1'b1)) begin
                tests_failed++;
                $display("FAIL all_full k=%0d: got seg=%b seg2=%b led3=%b expected 1000000 1000000 1", k, bus.seg, bus.seg2, bus.led3);
            end
        end
    endtask

    task automatic test_ir();
        bus.ir = 1'b0;
        repeat (4) @(negedge clk);
        bus.ir = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.arduino !== (k >= 3)) begin
                tests_failed++;
                $display("FAIL ir_latency k=%0d: got %b expected %b", k, bus.arduino, (k >= 3));
            end
        end
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) bus.ir = ~bus.ir;
            @(negedge clk);
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL ir_model k=%0d: got %b expected %b", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        bus.ldr = 4'b0000;
        bus.ir = 1'b1;
        repeat (12) @(negedge clk);
        bus.ldr = 4'b0011;
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== RESET_VEC) begin
            tests_failed++;
            $display("FAIL async_reset: got %b expected %b", obs, RESET_VEC);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== exp_vec()) begin
                tests_failed++;
                $display("FAIL restart_model k=%0d: got %b expected %b", k, obs, exp_vec());
            end
            tests_run++;
            if (bus.seg !== ((k < 8) ? DIG[4] : DIG[2])) begin
                tests_failed++;
                $display("FAIL restart_latency k=%0d: got %b expected %b", k, bus.seg, (k < 8) ? DIG[4] : DIG[2]);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int n = 0; n < 80; n++) begin
            bus.ldr = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) begin
                bus.ir = 1'($urandom_range(0, 1));
                @(negedge clk);
                tests_run++;
                if (obs !== exp_vec() || $countones({bus.led1, bus.led2, bus.led3}) != 1) begin
                    tests_failed++;
                    $display("FAIL random n=%0d k=%0d: got %b expected %b", n, k, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_wide();
        tests_run++;
        if (bus_w.seg2 !== 7'b1111001 || bus_w.seg !== 7'b0100100 || bus_w.led1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL wide_free: got seg2=%b seg=%b led1=%b expected 1111001 0100100 1", bus_w.seg2, bus_w.seg, bus_w.led1);
        end
        bus_w.ldr = 12'h007;
        repeat (10) @(negedge clk);
        tests_run++;
        if (bus_w.seg2 !== 7'b1000000 || bus_w.seg !== 7'b0010000 || bus_w.led2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL wide_nine: got seg2=%b seg=%b led2=%b expected 1000000 0010000 1", bus_w.seg2, bus_w.seg, bus_w.led2);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_back_to_back();
        test_ir();
        test_async_reset();
        test_random();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/slot_monitor.md
Name: slot_monitor

Overview:
- Multi-channel occupancy monitor; parametrised successor of the single-LDR display block.
- Watches N_CH light sensors (1 = slot occupied), synchronises and debounces each, and counts free slots.
- Shows the free count as two decimal digits on the 7-segment pair and drives three status LEDs.
- Also carries the synchronised IR pass-through to the Arduino and the heartbeat toggle on p1.

Parameters:
- N_CH, 4, number of sensor channels; legal range 1..99.
- DEB_CYCLES, 16, consecutive stable cycles required to accept a sensor change; legal range >=2.
- HB_DIV, 25000000, clk cycles per p1 half-period; legal range >=1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous reset, active-low.
- ldr  input  N_CH  raw sensor per slot (async); 1 = occupied.
- ir  input  1  raw IR detector (async).
- arduino  output  1  synchronised IR copy.
- p1  output  1  heartbeat square wave.
- seg  output  7  ones digit, active-low, bit0=a .. bit6=g.
- seg2  output  7  tens digit, same encoding.
- led1  output  1  all slots free.
- led2  output  1  partially occupied.
- led3  output  1  all slots occupied (full).

Behaviour:
- Clocking and reset:
  - One clock (clk); reset_n is asynchronous and active-low.
  - All flops clear immediately on reset_n low, including mid-debounce.
  - Every output is registered.
- Reset values:
  - Occupied count = 0, so free = N_CH.
  - seg/seg2 show N_CH; for N_CH=4: seg=0011001, seg2=1000000.
  - led1=1, led2=0, led3=0 (led2=0 also when N_CH=1).
  - arduino=0, p1=0, all debounce counters=0, all stable bits=0.
- Synchronisers: each ldr bit and ir pass through a 2-flop synchroniser.
- arduino: registered copy of synced ir; 3 cycles latency from the ir edge.
- Per-channel debounce:
  - Compare the synced bit with the stable bit.
  - On match: counter <= 0.
  - On mismatch: counter increments; when counter == DEB_CYCLES-1 and still mismatched, stable <= synced and counter <= 0.
  - Counter width = clog2(DEB_CYCLES).
  - A pulse or glitch shorter than DEB_CYCLES synced cycles produces no change.
- Counting:
  - occ <= popcount(stable) each cycle; width clog2(N_CH+1).
  - free = N_CH - occ, which never underflows.
  - Simultaneous changes on several channels are all reflected in the same occ update; no event is lost.
- Display (all registered from free):
  - tens = free/10, ones = free%10.
  - seg2 shows tens, including a leading 0 (not blanked).
  - Total latency from a clean ldr edge to the seg/LED change is exactly DEB_CYCLES+4 cycles: 2 sync + DEB_CYCLES debounce + 1 count + 1 output.
- LEDs: exactly one of led1/led2/led3 is high at all times.
  - led1 = (free==N_CH).
  - led3 = (free==0).
  - led2 = otherwise.
- Heartbeat:
  - Counter from 0 to HB_DIV-1, then wraps; p1 toggles on the wrap.
  - First toggle occurs HB_DIV cycles after reset release.
  - Heartbeat is independent of the sensors.
- No handshake: inputs are levels, outputs are levels.

Decomposition:
- Package slot_monitor_pkg holds:
  - SEG_DIGIT[0..9] active-low constants: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A popcount function.
- One sub-module, ch_debounce: 2-flop sync + counter + stable bit, parameter DEB_CYCLES. Instantiate N_CH times; the ir synchroniser stays inline.

Test Plan (N_CH=4, DEB_CYCLES=4, HB_DIV=8):
- Reset low, then release → seg=0011001, seg2=1000000, led1=1, led2=0, led3=0, p1=0, arduino=0; p1 rises 8 cycles after release and falls 8 later.
- ldr=0001, held → exactly 8 cycles later seg=0110000 (3), led2=1; other outputs unchanged before then.
- ldr[2] pulsed high for 3 synced cycles → no change on seg or LEDs; a 4-cycle pulse → count 2 shown, then returns once released for 4 cycles.
- ldr 0000→1111 in one cycle → seg=1000000, seg2=1000000, led3=1 after 8 cycles; no intermediate value is shown.
- ir toggling → arduino follows with 3-cycle latency; reset_n pulsed low mid-debounce (counter=2) → all outputs return to reset values immediately and the counter restarts from 0.
- N_CH=12, all free → seg2=1111001 (1), seg=0100100 (2); with 3 occupied → seg2=1000000, seg=0010000 (9).
